// File: rtl/fetch_decode_if.sv
// Issue bus between the fetch/decode stage and the register-file/data-memory stage.
// The stage drives the decoded fields and valid; the downstream stage drives ready.
interface fetch_decode_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] select;
    logic [4:0] rdst1;
    logic [4:0] rdst2;
    logic [4:0] rsrc1;
    logic [4:0] rsrc2;
    logic [7:0] imm_value;
    logic [7:0] imm_value2;
    logic [4:0] src_address;
    logic [4:0] dst_address;

    modport master (
        output issue_valid, select, rdst1, rdst2, rsrc1, rsrc2,
               imm_value, imm_value2, src_address, dst_address,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, select, rdst1, rdst2, rsrc1, rsrc2,
               imm_value, imm_value2, src_address, dst_address,
        output issue_ready
    );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode/issue stage: program memory with load port, pc, and an FSM that
// presents one decoded instruction at a time over a valid/ready issue bus.
module fetch_decode #(
    parameter int PC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    fetch_decode_if.master    iss,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_DECODE2, S_ISSUE, S_HALTED
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_LDI, OP_LDI2, OP_MOV, OP_LOAD, OP_STORE, OP_JMP, OP_HALT
    } op_e;

    typedef struct packed {
        logic [1:0] sel;
        logic [4:0] rdst1;
        logic [4:0] rdst2;
        logic [4:0] rsrc1;
        logic [4:0] rsrc2;
        logic [7:0] imm;
        logic [7:0] imm2;
        logic [4:0] src;
        logic [4:0] dst;
    } fields_t;

    // select=01 with all-zero indices is a harmless r0<-r0 move downstream.
    localparam fields_t FIELDS_RST = '{sel: 2'b01, default: '0};

    logic [15:0]     mem [2**PC_W];
    logic [15:0]     mem_rdata_q;
    logic            rd_en;

    state_e          state_q,  state_d;
    logic [PC_W-1:0] pc_q,     pc_d;
    logic            valid_q,  valid_d;
    logic            busy_q,   busy_d;
    logic            halted_q, halted_d;
    fields_t         fields_q, fields_d;
    logic [4:0]      w0_a_q,   w0_a_d;
    logic [7:0]      w0_b_q,   w0_b_d;

    op_e             op;
    logic [4:0]      fa;
    logic [7:0]      fb;

    // NOTE: program storage carries no reset so it maps onto RAM and survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_HALTED))
            mem[prog_addr] <= prog_data;
        if (rd_en)
            mem_rdata_q <= mem[pc_q];
    end

    function automatic fields_t decode_single(op_e o, logic [4:0] a, logic [7:0] b);
        fields_t f;
        f = '0;
        case (o)
            OP_LDI: begin
                f.sel   = 2'b00;
                f.rdst1 = a;  f.rdst2 = a;  f.rsrc1 = a;  f.rsrc2 = a;
                f.imm   = b;  f.imm2  = b;
            end
            OP_MOV:   begin f.sel = 2'b01; f.rdst1 = a; f.rsrc1 = b[4:0]; end
            OP_LOAD:  begin f.sel = 2'b10; f.rdst1 = a; f.src   = b[4:0]; end
            OP_STORE: begin f.sel = 2'b11; f.rsrc1 = a; f.dst   = b[4:0]; end
            default:  f = FIELDS_RST;
        endcase
        return f;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        fields_d = fields_q;
        w0_a_d   = w0_a_q;
        w0_b_d   = w0_b_q;
        rd_en    = 1'b0;
        op       = op_e'(mem_rdata_q[15:13]);
        fa       = mem_rdata_q[12:8];
        fb       = mem_rdata_q[7:0];

        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                rd_en   = 1'b1;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_NOP:  state_d = S_FETCH;
                    OP_JMP:  begin pc_d = fb[PC_W-1:0]; state_d = S_FETCH; end
                    OP_HALT: state_d = S_HALTED;
                    OP_LDI2: begin w0_a_d = fa; w0_b_d = fb; state_d = S_FETCH2; end
                    default: begin
                        fields_d = decode_single(op, fa, fb);
                        valid_d  = 1'b1;
                        state_d  = S_ISSUE;
                    end
                endcase
            end
            S_FETCH2: begin
                rd_en   = 1'b1;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE2;
            end
            S_DECODE2: begin
                // Word1's op field is deliberately ignored.
                fields_d       = '0;
                fields_d.sel   = 2'b00;
                fields_d.rdst1 = w0_a_q;
                fields_d.rsrc1 = w0_a_q;
                fields_d.imm   = w0_b_q;
                fields_d.rdst2 = fa;
                fields_d.rsrc2 = fa;
                fields_d.imm2  = fb;
                valid_d        = 1'b1;
                state_d        = S_ISSUE;
            end
            S_ISSUE: begin
                if (iss.issue_ready) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        busy_d   = !(state_d inside {S_IDLE, S_HALTED});
        halted_d = (state_d == S_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fields_q <= FIELDS_RST;
            w0_a_q   <= '0;
            w0_b_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            fields_q <= fields_d;
            w0_a_q   <= w0_a_d;
            w0_b_q   <= w0_b_d;
        end
    end

    assign iss.issue_valid = valid_q;
    assign iss.select      = fields_q.sel;
    assign iss.rdst1       = fields_q.rdst1;
    assign iss.rdst2       = fields_q.rdst2;
    assign iss.rsrc1       = fields_q.rsrc1;
    assign iss.rsrc2       = fields_q.rsrc2;
    assign iss.imm_value   = fields_q.imm;
    assign iss.imm_value2  = fields_q.imm2;
    assign iss.src_address = fields_q.src;
    assign iss.dst_address = fields_q.dst;
    assign pc              = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: inputs change and outputs are sampled on the
// falling edge; field bundles are compared as one packed word per instruction.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;

    // {select, rdst1, rdst2, rsrc1, rsrc2, imm_value, imm_value2, src_address, dst_address}
    localparam logic [47:0] F_RST  = {2'b01, 46'd0};
    localparam logic [47:0] F_LDI  = {2'b00, 5'd1, 5'd1, 5'd1, 5'd1, 8'h55, 8'h55, 5'd0, 5'd0};
    localparam logic [47:0] F_LDI2 = {2'b00, 5'd2, 5'd4, 5'd2, 5'd4, 8'h03, 8'h09, 5'd0, 5'd0};
    localparam logic [47:0] F_STO  = {2'b11, 5'd0, 5'd0, 5'd3, 5'd0, 8'h00, 8'h00, 5'd0, 5'd30};
    localparam logic [47:0] F_MOV  = {2'b01, 5'd5, 5'd0, 5'd2, 5'd0, 8'h00, 8'h00, 5'd0, 5'd0};
    localparam logic [47:0] F_LOAD = {2'b10, 5'd6, 5'd0, 5'd0, 5'd0, 8'h00, 8'h00, 5'd17, 5'd0};
    localparam logic [47:0] F_LDIA = {2'b00, 5'd10, 5'd10, 5'd10, 5'd10, 8'h12, 8'h12, 5'd0, 5'd0};

    fetch_decode_if bus ();

    fetch_decode #(.PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .iss       (bus),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && bus.issue_valid && bus.issue_ready) xfers++;

    function automatic logic [47:0] obs();
        return {bus.select, bus.rdst1, bus.rdst2, bus.rsrc1, bus.rsrc2,
                bus.imm_value, bus.imm_value2, bus.src_address, bus.dst_address};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_mem(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.issue_valid && n < 60);
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!halted && n < 600);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.issue_valid); end
        checks++; if ({busy, halted} !== 2'b00) begin failures++; $display("FAIL reset_busy_halted got=%b exp=00", {busy, halted}); end
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (obs() !== F_RST) begin failures++; $display("FAIL reset_fields got=%h exp=%h", obs(), F_RST); end
    endtask

    task automatic test_ldi_halt();
        int n, x0;
        do_reset();
        write_mem(8'd0, 16'h2155);
        write_mem(8'd1, 16'hE000);
        bus.issue_ready = 1'b1;
        x0 = xfers;
        kick();
        wait_valid(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL ldi_latency got=%0d exp=2", n); end
        checks++; if (obs() !== F_LDI) begin failures++; $display("FAIL ldi_fields got=%h exp=%h", obs(), F_LDI); end
        checks++; if ({busy, pc} !== {1'b1, 8'd1}) begin failures++; $display("FAIL ldi_busy_pc got=%h exp=101", {busy, pc}); end
        @(negedge clk);
        checks++; if (bus.issue_valid !== 1'b0) begin failures++; $display("FAIL ldi_pulse got=%b exp=0", bus.issue_valid); end
        wait_halt(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL halt_latency got=%0d exp=2", n); end
        checks++; if ({halted, busy, pc} !== {2'b10, 8'd2}) begin failures++; $display("FAIL halt_state got=%h exp=202", {halted, busy, pc}); end
        checks++; if (obs() !== F_LDI) begin failures++; $display("FAIL halt_fields_held got=%h exp=%h", obs(), F_LDI); end
        checks++; if (xfers - x0 !== 1) begin failures++; $display("FAIL ldi_xfers got=%0d exp=1", xfers - x0); end
        kick();
        @(negedge clk);
        checks++; if ({halted, busy, pc} !== {2'b10, 8'd2}) begin failures++; $display("FAIL halted_ignores_start got=%h exp=202", {halted, busy, pc}); end
    endtask

    task automatic test_ldi2_wrap();
        int n;
        do_reset();
        write_mem(8'd0, 16'h0409);
        write_mem(8'd1, 16'hC0FF);
        write_mem(8'd255, 16'h4203);
        bus.issue_ready = 1'b1;
        kick();
        wait_valid(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL ldi2_latency got=%0d exp=8", n); end
        checks++; if (pc !== 8'd1) begin failures++; $display("FAIL ldi2_pc_wrap got=%h exp=01", pc); end
        checks++; if (obs() !== F_LDI2) begin failures++; $display("FAIL ldi2_fields got=%h exp=%h", obs(), F_LDI2); end
    endtask

    task automatic test_store_stall();
        int n, x0;
        do_reset();
        write_mem(8'd0, 16'hA31E);
        write_mem(8'd1, 16'hE000);
        bus.issue_ready = 1'b0;
        x0 = xfers;
        kick();
        wait_valid(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL store_latency got=%0d exp=2", n); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus.issue_valid, pc} !== {1'b1, 8'd1}) begin failures++; $display("FAIL stall_valid_pc cyc=%0d got=%h exp=101", i, {bus.issue_valid, pc}); end
            checks++; if (obs() !== F_STO) begin failures++; $display("FAIL stall_fields cyc=%0d got=%h exp=%h", i, obs(), F_STO); end
        end
        bus.issue_ready = 1'b1;
        wait_halt(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL store_to_halt got=%0d exp=3", n); end
        checks++; if (xfers - x0 !== 1) begin failures++; $display("FAIL store_xfers got=%0d exp=1", xfers - x0); end
    endtask

    task automatic test_back_to_back();
        int n, x0;
        do_reset();
        write_mem(8'd0, 16'h6502);
        write_mem(8'd1, 16'h8611);
        write_mem(8'd2, 16'h0000);
        write_mem(8'd3, 16'hE000);
        bus.issue_ready = 1'b1;
        x0 = xfers;
        kick();
        wait_valid(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL mov_latency got=%0d exp=2", n); end
        checks++; if (obs() !== F_MOV) begin failures++; $display("FAIL mov_fields got=%h exp=%h", obs(), F_MOV); end
        wait_valid(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL load_cpi got=%0d exp=3", n); end
        checks++; if (obs() !== F_LOAD) begin failures++; $display("FAIL load_fields got=%h exp=%h", obs(), F_LOAD); end
        wait_halt(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL nop_halt_cycles got=%0d exp=5", n); end
        checks++; if (pc !== 8'd4) begin failures++; $display("FAIL nop_halt_pc got=%h exp=04", pc); end
        checks++; if (xfers - x0 !== 2) begin failures++; $display("FAIL b2b_xfers got=%0d exp=2", xfers - x0); end
    endtask

    task automatic test_rst_mid_issue();
        int n, x0;
        do_reset();
        bus.issue_ready = 1'b0;
        kick();
        wait_valid(n);
        checks++; if (obs() !== F_MOV) begin failures++; $display("FAIL pre_rst_fields got=%h exp=%h", obs(), F_MOV); end
        x0 = xfers;
        bus.issue_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus.issue_valid, busy, halted, pc} !== 11'd0) begin failures++; $display("FAIL rst_mid_state got=%h exp=000", {bus.issue_valid, busy, halted, pc}); end
        checks++; if (obs() !== F_RST) begin failures++; $display("FAIL rst_mid_fields got=%h exp=%h", obs(), F_RST); end
        checks++; if (xfers !== x0) begin failures++; $display("FAIL rst_mid_xfer got=%0d exp=%0d", xfers, x0); end
        rst = 1'b0;
        kick();
        wait_valid(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL rerun_latency got=%0d exp=2", n); end
        checks++; if (obs() !== F_MOV) begin failures++; $display("FAIL rerun_fields got=%h exp=%h", obs(), F_MOV); end
    endtask

    task automatic test_prog_we();
        int n;
        do_reset();
        write_mem(8'd0, 16'h2155);
        write_mem(8'd1, 16'hE000);
        bus.issue_ready = 1'b0;
        kick();
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h2777;
        wait_valid(n);
        repeat (2) @(negedge clk);
        prog_we = 1'b0;
        do_reset();
        bus.issue_ready = 1'b1;
        kick();
        wait_valid(n);
        checks++; if (obs() !== F_LDI) begin failures++; $display("FAIL we_busy_ignored got=%h exp=%h", obs(), F_LDI); end
        do_reset();
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h2A12;
        start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_valid(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL we_start_latency got=%0d exp=2", n); end
        checks++; if (obs() !== F_LDIA) begin failures++; $display("FAIL we_start_visible got=%h exp=%h", obs(), F_LDIA); end
    endtask

    initial begin
        bus.issue_ready = 1'b1;
        test_reset();
        test_ldi_halt();
        test_ldi2_wrap();
        test_store_stall();
        test_back_to_back();
        test_rst_mid_issue();
        test_prog_we();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
